tone_mixer_n: RTL and testbench
===============================

# tone_mixer_n

Parametrised N-channel square-wave tone generator and saturating mixer that runs directly in the audio sample clock domain. It replaces the fixed three-channel external-PSG path with per-channel period, volume, enable and key-on registers. It also adds an optional per-channel linear decay envelope. It produces a signed 16-bit sample stream for the audio serialiser.

## Interface
- NUM_CH, 3: number of tone channels (1..8)
- PERIOD_W, 12: width of the half-period register, in ticks
- VOL_W, 4: volume width
- OUT_W, 16: output sample width; requires OUT_W-1 > VOL_W
- ENV_PRE, 256: envelope prescaler, in ticks
- ADDR_W, $clog2(NUM_CH)+2: register address width; the channel number is addr[ADDR_W-1:2] and the register number is addr[1:0]

Ports:
- I_clk_audio  in  1  audio clock
- I_reset_n  in  1  reset, synchronous, active-low
- I_tick  in  1  sample strobe; one pulse advances all channels by one sample
- I_wr_en  in  1  register write strobe; always accepted, no ready
- I_wr_addr  in  ADDR_W  register address
- I_wr_data  in  16  write data
- O_sample  out  OUT_W  signed two's-complement mixed sample
- O_sample_valid  out  1  one-cycle pulse when O_sample updates
- O_active  out  NUM_CH  per channel: enable=1 and vol_eff!=0

## Operation
Register map per channel (reg number = addr[1:0]):
- 0: period, data[PERIOD_W-1:0]
- 1: volume, data[VOL_W-1:0]
- 2: ctrl. bit0 enable; bit1 decay mode; bit2 key-on, a self-clearing action that is never stored
- 3: decay rate, data[7:0]

Writes with channel number >= NUM_CH are ignored.

Per-channel state: cnt[PERIOD_W], sq, vol_eff[VOL_W], pre_cnt, rate_cnt.

Tone update, on a cycle with I_tick=1, for each channel with enable=1 and period!=0:
- if cnt >= period-1: cnt<=0 and sq<=~sq
- otherwise cnt<=cnt+1
- The >= compare makes a period shrink below cnt toggle on the next tick; there is no wrap-around.

Held channels:
- A disabled channel holds cnt at 0 and holds sq.
- A channel with period=0 holds cnt and sq.

Key-on: sets cnt<=0, sq<=1, vol_eff<=volume register (the new value if written in the same cycle), and pre_cnt=rate_cnt=0.

Envelope:
- Decay mode=0: vol_eff follows the volume register every cycle.
- Decay mode=1: on each tick pre_cnt advances. At ENV_PRE-1 it wraps and rate_cnt advances. At rate_cnt==rate it wraps and vol_eff decrements, saturating at 0.
- Step interval is (rate+1)*ENV_PRE ticks.
- A volume write while decay mode=1 does not change vol_eff until the next key-on.

Channel value:
- amp = vol_eff << (OUT_W-1-VOL_W)
- contribution = +amp if sq=1, -amp if sq=0, and 0 if enable=0 or period=0.

Mixing:
- The sum is formed at width OUT_W+$clog2(NUM_CH)+1, sign-extended, with no wrap.
- It is clipped to [-2^(OUT_W-1), 2^(OUT_W-1)-1].

Simultaneous events:
- A key-on write and a tick on the same channel in the same cycle: key-on wins, the tick is not applied, and the channel is not advanced that tick.
- A period, volume or rate write coinciding with a tick: the tick uses the old register value; the new value applies from the next tick.

## Timing
- Reset, synchronous, sampled on rising I_clk_audio: all registers and channel state go to 0, O_sample=0, O_sample_valid=0, O_active=0. The pipeline is flushed; a sample in flight when reset is asserted is never emitted.
- Edge E0, where I_tick=1 is sampled: channel state advances.
- Edge E0+1: sum register captures the mix of the post-E0 state.
- Edge E0+2: O_sample<=clip(sum) and O_sample_valid=1 for exactly one cycle.
- Latency is 2 cycles. Back-to-back ticks are legal and give back-to-back valid pulses.
- Register writes take effect at the edge following the write cycle. O_active reflects the current registers with no pipeline delay.
- O_sample holds its value between valid pulses.

## Test plan
- Reset: hold I_reset_n=0 for 1 cycle during tone playback -> next cycle O_sample=0, O_sample_valid=0, O_active=0; no valid pulse for 2 cycles after release without a tick.
- Single tone: ch0 period=4, vol=15, ctrl=0b101, tick every cycle -> first valid 2 cycles after the first tick. Samples are +30720 x3, then alternating runs of -30720 x4 and +30720 x4. O_active=3'b001.
- Saturation: all 3 channels at period=8, vol=15, key-on in the same cycle -> +32767 while all are high, -32768 while all are low. Change ch2 vol=0 -> ±30720*2 still clips to +32767/-32768. Disable ch1 and ch2 -> ±30720.
- Decay: ENV_PRE=4, ch0 vol=3, rate=0, ctrl=0b111 -> vol_eff goes 3,2,1,0 every 4 ticks; amp sequence 6144, 4096, 2048, 0. O_active[0] clears when vol_eff reaches 0.
- Period shrink: ch0 period=20, let cnt reach 10, write period=4 -> toggle on the next tick, cnt=0, then half-period of 4 ticks.
- Boundary writes: write addr 12 (channel 3 with NUM_CH=3) -> no state change. Key-on write coincident with a tick -> cnt=0 and sq=1 after that edge.

Source files
------------

// File: rtl/tone_mixer_n.sv
// tone_mixer_n: N-channel square-wave tone generator with optional linear
// decay envelope and a saturating mixer, clocked by the audio sample clock.
// Tick at edge E0 advances channels, E0+1 registers the raw sum, E0+2
// presents the clipped sample with a one-cycle valid pulse.

// Per-channel registers, tone counter and decay envelope.
module tone_mixer_n_ch #(
  parameter int PERIOD_W = 12,
  parameter int VOL_W    = 4,
  parameter int OUT_W    = 16,
  parameter int ENV_PRE  = 256
) (
  input  logic             I_clk_audio,
  input  logic             I_reset_n,
  input  logic             tick_i,
  input  logic             wr_sel_i,
  input  logic [1:0]       wr_reg_i,
  input  logic [15:0]      wr_data_i,
  output logic [OUT_W-1:0] contrib_o,
  output logic             active_o
);
  localparam int PRE_W = (ENV_PRE > 1) ? $clog2(ENV_PRE) : 1;
  localparam int SH    = OUT_W - 1 - VOL_W;

  logic [PERIOD_W-1:0] period_q, period_d, cnt_q, cnt_d;
  logic [VOL_W-1:0]    vol_q, vol_d, env_q, env_d;
  logic [7:0]          rate_q, rate_d, rcnt_q, rcnt_d;
  logic [PRE_W-1:0]    pre_q, pre_d;
  logic                en_q, en_d, dec_q, dec_d, sq_q, sq_d;
  logic                key_on;
  logic [OUT_W-1:0]    amp;
  logic                unused_data;

  // Only the low bits of the data bus carry register fields.
  assign unused_data = ^wr_data_i;
  assign key_on = wr_sel_i && (wr_reg_i == 2'd2) && wr_data_i[2];

  // Next state: register writes, key-on, tone counter and envelope. Ticks
  // always act on the pre-write register values.
  always_comb begin
    period_d = period_q;
    vol_d    = vol_q;
    en_d     = en_q;
    dec_d    = dec_q;
    rate_d   = rate_q;
    cnt_d    = cnt_q;
    sq_d     = sq_q;
    env_d    = env_q;
    pre_d    = pre_q;
    rcnt_d   = rcnt_q;
    if (wr_sel_i) begin
      case (wr_reg_i)
        2'd0:    period_d = wr_data_i[PERIOD_W-1:0];
        2'd1:    vol_d    = wr_data_i[VOL_W-1:0];
        2'd2:    begin en_d = wr_data_i[0]; dec_d = wr_data_i[1]; end
        default: rate_d   = wr_data_i[7:0];
      endcase
    end
    if (key_on) begin
      // Key-on overrides a coincident tick on this channel.
      cnt_d  = '0;
      sq_d   = 1'b1;
      env_d  = vol_d;
      pre_d  = '0;
      rcnt_d = '0;
    end else begin
      if (!en_q) begin
        cnt_d = '0;
      end else if (tick_i && (period_q != '0)) begin
        // >= so a shrunk period toggles on the very next tick.
        if (cnt_q >= period_q - PERIOD_W'(1)) begin
          cnt_d = '0;
          sq_d  = ~sq_q;
        end else begin
          cnt_d = cnt_q + PERIOD_W'(1);
        end
      end
      if (!dec_q) begin
        env_d = vol_d;
      end else if (tick_i) begin
        if (pre_q == PRE_W'(ENV_PRE - 1)) begin
          pre_d = '0;
          if (rcnt_q == rate_q) begin
            rcnt_d = '0;
            if (env_q != '0) env_d = env_q - VOL_W'(1);
          end else begin
            rcnt_d = rcnt_q + 8'd1;
          end
        end else begin
          pre_d = pre_q + PRE_W'(1);
        end
      end
    end
  end

  // Channel state registers.
  always_ff @(posedge I_clk_audio) begin
    if (!I_reset_n) begin
      period_q <= '0; vol_q <= '0; en_q <= 1'b0; dec_q <= 1'b0; rate_q <= '0;
      cnt_q <= '0; sq_q <= 1'b0; env_q <= '0; pre_q <= '0; rcnt_q <= '0;
    end else begin
      period_q <= period_d; vol_q <= vol_d; en_q <= en_d; dec_q <= dec_d;
      rate_q <= rate_d; cnt_q <= cnt_d; sq_q <= sq_d; env_q <= env_d;
      pre_q <= pre_d; rcnt_q <= rcnt_d;
    end
  end

  assign amp       = OUT_W'(env_q) << SH;
  assign contrib_o = (en_q && (period_q != '0)) ? (sq_q ? amp : (OUT_W'(0) - amp)) : '0;
  assign active_o  = en_q && (env_q != '0);
endmodule

module tone_mixer_n #(
  parameter int NUM_CH   = 3,
  parameter int PERIOD_W = 12,
  parameter int VOL_W    = 4,
  parameter int OUT_W    = 16,
  parameter int ENV_PRE  = 256,
  parameter int ADDR_W   = $clog2(NUM_CH) + 2
) (
  input  logic              I_clk_audio,
  input  logic              I_reset_n,
  input  logic              I_tick,
  input  logic              I_wr_en,
  input  logic [ADDR_W-1:0] I_wr_addr,
  input  logic [15:0]       I_wr_data,
  output logic [OUT_W-1:0]  O_sample,
  output logic              O_sample_valid,
  output logic [NUM_CH-1:0] O_active
);
  localparam int SUM_W = OUT_W + $clog2(NUM_CH) + 1;
  localparam logic signed [SUM_W-1:0] MAXV = {{(SUM_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] MINV = {{(SUM_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic [NUM_CH-1:0][OUT_W-1:0] contrib;
  logic [ADDR_W-1:0]            wr_ch;
  logic signed [SUM_W-1:0]      sum_d, sum_q;
  logic [OUT_W-1:0]             clip_d, sample_q;
  logic [2:0]                   vld_pipe_q;

  // Channel numbers >= NUM_CH match no instance, so those writes vanish.
  assign wr_ch = I_wr_addr >> 2;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    tone_mixer_n_ch #(
      .PERIOD_W(PERIOD_W), .VOL_W(VOL_W), .OUT_W(OUT_W), .ENV_PRE(ENV_PRE)
    ) u_ch (
      .I_clk_audio(I_clk_audio),
      .I_reset_n  (I_reset_n),
      .tick_i     (I_tick),
      .wr_sel_i   (I_wr_en && (wr_ch == ADDR_W'(g))),
      .wr_reg_i   (I_wr_addr[1:0]),
      .wr_data_i  (I_wr_data),
      .contrib_o  (contrib[g]),
      .active_o   (O_active[g])
    );
  end

  // Sign-extended sum, wide enough that it never wraps.
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < NUM_CH; i++)
      sum_d = sum_d + {{(SUM_W-OUT_W){contrib[i][OUT_W-1]}}, contrib[i]};
  end

  // Saturate the registered sum to the output range.
  always_comb begin
    clip_d = sum_q[OUT_W-1:0];
    if (sum_q > MAXV)      clip_d = MAXV[OUT_W-1:0];
    else if (sum_q < MINV) clip_d = MINV[OUT_W-1:0];
  end

  // Two-stage output pipeline; reset drops any sample in flight.
  always_ff @(posedge I_clk_audio) begin
    if (!I_reset_n) begin
      vld_pipe_q <= '0;
      sum_q      <= '0;
      sample_q   <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[1:0], I_tick};
      sum_q      <= sum_d;
      if (vld_pipe_q[1]) sample_q <= clip_d;
    end
  end

  assign O_sample       = sample_q;
  assign O_sample_valid = vld_pipe_q[2];
endmodule

// File: tb/tb_tone_mixer_n.sv
// tb_tone_mixer_n: directed plus random stimulus against a spec-level model;
// expected samples are queued with their due cycle and a monitor checks them.
module tb_tone_mixer_n;
  localparam int NCH  = 3;
  localparam int EPRE = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0, tick = 1'b0, wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic [15:0] sample;
  logic        valid;
  logic [2:0]  active;

  always #5 clk = ~clk;

  tone_mixer_n #(.NUM_CH(NCH), .ENV_PRE(EPRE)) dut (
    .I_clk_audio(clk), .I_reset_n(rst_n), .I_tick(tick), .I_wr_en(wr_en),
    .I_wr_addr(wr_addr), .I_wr_data(wr_data), .O_sample(sample),
    .O_sample_valid(valid), .O_active(active)
  );

  int errors = 0, checks = 0, cyc = 0;
  int exp_q[$], due_q[$];
  int last_s = 0;
  int m_per[NCH], m_vol[NCH], m_en[NCH], m_dec[NCH], m_rate[NCH];
  int m_cnt[NCH], m_sq[NCH], m_veff[NCH], m_pre[NCH], m_rc[NCH];

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int exp_mix();
    int s = 0;
    for (int c = 0; c < NCH; c++)
      if (m_en[c] != 0 && m_per[c] != 0)
        s += (m_sq[c] != 0 ? 1 : -1) * m_veff[c] * 2048;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return s;
  endfunction

  function automatic int exp_active();
    int a = 0;
    for (int c = 0; c < NCH; c++)
      if (m_en[c] != 0 && m_veff[c] != 0) a |= (1 << c);
    return a;
  endfunction

  // Behavioural model of one clock edge.
  task automatic model_edge(bit r, bit t, bit we, int a, int d);
    int ch, rg, old_dec[NCH];
    bit vw, ko;
    if (!r) begin
      for (int c = 0; c < NCH; c++) begin
        m_per[c] = 0; m_vol[c] = 0; m_en[c] = 0; m_dec[c] = 0; m_rate[c] = 0;
        m_cnt[c] = 0; m_sq[c] = 0; m_veff[c] = 0; m_pre[c] = 0; m_rc[c] = 0;
      end
      exp_q.delete(); due_q.delete(); last_s = 0;
      return;
    end
    ch = a >> 2; rg = a & 3;
    vw = we && ch < NCH;
    ko = vw && rg == 2 && d[2];
    for (int c = 0; c < NCH; c++) old_dec[c] = m_dec[c];
    // Tick acts with the registers as they were before this edge's write.
    for (int c = 0; c < NCH; c++) begin
      if (ko && c == ch) continue;
      if (m_en[c] == 0) m_cnt[c] = 0;
      else if (t && m_per[c] != 0) begin
        if (m_cnt[c] >= m_per[c] - 1) begin m_cnt[c] = 0; m_sq[c] ^= 1; end
        else m_cnt[c]++;
      end
      if (m_dec[c] != 0 && t) begin
        m_pre[c]++;
        if (m_pre[c] == EPRE) begin
          m_pre[c] = 0;
          if (m_rc[c] == m_rate[c]) begin
            m_rc[c] = 0;
            if (m_veff[c] > 0) m_veff[c]--;
          end else m_rc[c] = (m_rc[c] + 1) & 255;
        end
      end
    end
    if (vw) begin
      case (rg)
        0: m_per[ch] = d & 4095;
        1: m_vol[ch] = d & 15;
        2: begin m_en[ch] = d & 1; m_dec[ch] = (d >> 1) & 1; end
        default: m_rate[ch] = d & 255;
      endcase
    end
    for (int c = 0; c < NCH; c++)
      if (old_dec[c] == 0) m_veff[c] = m_vol[c];
    if (ko) begin
      m_cnt[ch] = 0; m_sq[ch] = 1; m_veff[ch] = m_vol[ch]; m_pre[ch] = 0; m_rc[ch] = 0;
    end
    if (t) begin
      exp_q.push_back(exp_mix());
      due_q.push_back(cyc + 2);
    end
  endtask

  // One clock: drive at negedge, update model at posedge, check O_active.
  task automatic step(bit r, bit t, bit we, int a, int d);
    rst_n = r; tick = t; wr_en = we; wr_addr = a[3:0]; wr_data = d[15:0];
    @(posedge clk);
    cyc++;
    model_edge(r, t, we, a, d);
    @(negedge clk);
    chk("active", int'(active), exp_active());
  endtask

  task automatic wr(int ch, int rg, int d, bit t = 1'b0);
    step(1'b1, t, 1'b1, ch * 4 + rg, d);
  endtask

  task automatic idle(int n, bit t);
    for (int i = 0; i < n; i++) step(1'b1, t, 1'b0, 0, 0);
  endtask

  // Monitor: compares each valid sample against the queue and its due cycle.
  initial begin
    int e, due;
    forever begin
      @(negedge clk);
      if (due_q.size() > 0 && due_q[0] < cyc) begin
        checks++; errors++;
        $display("FAIL missing_valid: sample due cycle %0d, now %0d", due_q[0], cyc);
        void'(exp_q.pop_front()); void'(due_q.pop_front());
      end
      if (valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_valid at cycle %0d: sample %0d", cyc, int'($signed(sample)));
        end else begin
          e = exp_q.pop_front(); due = due_q.pop_front();
          chk("sample", int'($signed(sample)), e);
          chk("latency", cyc, due);
        end
        last_s = int'($signed(sample));
      end else begin
        chk("hold", int'($signed(sample)), last_s);
      end
    end
  end

  initial begin
    int r, a, d;
    @(negedge clk);
    step(1'b0, 1'b0, 1'b0, 0, 0);
    step(1'b0, 1'b1, 1'b0, 0, 0);
    chk("rst_sample", int'(sample), 0);
    chk("rst_valid", int'(valid), 0);

    // Single tone on ch0.
    wr(0, 0, 4); wr(0, 1, 15); wr(0, 2, 5);
    idle(20, 1'b1);

    // Reset during playback with a tick in the same cycle.
    step(1'b0, 1'b1, 1'b0, 0, 0);
    chk("rst_mid_sample", int'(sample), 0);
    chk("rst_mid_valid", int'(valid), 0);
    chk("rst_mid_active", int'(active), 0);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 1'b0, 0, 0);
      chk("post_rst_valid", int'(valid), 0);
    end

    // Saturation: all channels aligned by key-ons with no ticks between.
    for (int c = 0; c < NCH; c++) begin wr(c, 0, 8); wr(c, 1, 15); wr(c, 2, 1); end
    for (int c = 0; c < NCH; c++) wr(c, 2, 5);
    idle(20, 1'b1);
    wr(2, 1, 0);
    idle(20, 1'b1);
    wr(1, 2, 0); wr(2, 2, 0);
    idle(20, 1'b1);

    // Decay envelope on ch0.
    wr(0, 1, 3); wr(0, 3, 0); wr(0, 2, 7);
    idle(20, 1'b1);

    // Period shrink below the running count.
    wr(0, 2, 5); wr(0, 1, 15); wr(0, 0, 20);
    idle(10, 1'b1);
    wr(0, 0, 4);
    idle(12, 1'b1);

    // Out-of-range channel writes and key-on coincident with a tick.
    wr(3, 0, 5); wr(3, 2, 5); wr(3, 1, 0);
    idle(3, 1'b1);
    wr(0, 2, 5, 1'b1);
    idle(6, 1'b1);
    wr(1, 2, 5, 1'b1); wr(0, 0, 6, 1'b1); wr(0, 1, 9, 1'b1);
    idle(6, 1'b1);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 199));
      if (r == 0) begin
        step(1'b0, $urandom_range(0, 1) == 1, 1'b0, 0, 0);
      end else if (r < 50) begin
        a = int'($urandom_range(0, 15));
        case (a & 3)
          0: d = int'($urandom_range(0, 12)) | (int'($urandom_range(0, 15)) << 12);
          1: d = int'($urandom_range(0, 65535));
          2: d = int'($urandom_range(0, 7)) | (int'($urandom_range(0, 255)) << 8);
          default: d = int'($urandom_range(0, 3)) | (int'($urandom_range(0, 255)) << 8);
        endcase
        step(1'b1, $urandom_range(0, 9) < 7, 1'b1, a, d);
      end else begin
        step(1'b1, $urandom_range(0, 9) < 7, 1'b0, 0, 0);
      end
    end

    idle(4, 1'b0);
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
